// File: rtl/multi_line_buf_if.sv
// axi4_stream_if: AXI4-Stream video channel with source (master) and sink (slave) views
interface axi4_stream_if #(
   parameter int TDATA_WIDTH = 32
) ();
   logic [TDATA_WIDTH-1:0] tdata;
   logic                   tvalid;
   logic                   tready;
   logic                   tlast;
   logic                   tuser;
   modport master (output tdata, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/multi_line_buf.sv
// multi_line_buf: ring of line slots that buffers AXI4-Stream video lines and replays the oldest on demand
module multi_line_buf #(
   parameter int MAX_LINE_SIZE = 1920,
   parameter int LINES_CNT = 4,
   parameter int TDATA_WIDTH = 32,
   parameter int PX_WIDTH = 30,
   localparam int ADDR_WIDTH = $clog2(MAX_LINE_SIZE + 1),
   localparam int CNT_WIDTH = $clog2(LINES_CNT + 1),
   localparam int SLOT_WIDTH = ($clog2(LINES_CNT) > 1) ? $clog2(LINES_CNT) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 pop_line_i,
   input  logic                 flush_line_i,
   axi4_stream_if.slave         video_i,
   axi4_stream_if.master        video_o,
   output logic [CNT_WIDTH-1:0] lines_cnt_o,
   output logic                 empty_o,
   output logic                 full_o,
   output logic                 rd_busy_o
);
   localparam int DEPTH = LINES_CNT * (2 ** ADDR_WIDTH);

   logic [PX_WIDTH-1:0]   mem [DEPTH];
   logic [PX_WIDTH-1:0]   rdata;
   logic [SLOT_WIDTH-1:0] wr_slot, rd_slot, w_slot, rd_next;
   logic [ADDR_WIDTH-1:0] wr_ptr, w_ptr, a_ptr;
   logic [ADDR_WIDTH-1:0] line_size [LINES_CNT];
   logic [LINES_CNT-1:0]  sof;
   logic [CNT_WIDTH-1:0]  cnt;
   logic                  drop_mode, rd_busy, a_vld, o_vld, o_last, o_user;
   logic                  wr_acc, sof_beat, we, commit, adv, a_last, done, flush_ok, free, pop_ok;

   function automatic logic [SLOT_WIDTH-1:0] inc(input logic [SLOT_WIDTH-1:0] s);
      return (s == SLOT_WIDTH'(LINES_CNT - 1)) ? '0 : s + 1'b1;
   endfunction

   assign lines_cnt_o = cnt;
   assign empty_o     = cnt == '0;
   assign full_o      = cnt == CNT_WIDTH'(LINES_CNT);
   assign rd_busy_o   = rd_busy;

   // overlong-line tails are swallowed even when every slot is occupied
   assign video_i.tready = !full_o || drop_mode;
   assign wr_acc   = video_i.tvalid && video_i.tready;
   assign sof_beat = wr_acc && video_i.tuser;
   // a frame restart lands at slot 0, pixel 0 regardless of current pointers
   assign w_slot   = sof_beat ? '0 : wr_slot;
   assign w_ptr    = sof_beat ? '0 : wr_ptr;
   assign we       = wr_acc && (sof_beat || !drop_mode);
   assign commit   = we && (video_i.tlast || w_ptr == ADDR_WIDTH'(MAX_LINE_SIZE - 1));

   // the address stage only moves when the output register can take its beat
   assign adv      = !o_vld || video_o.tready;
   assign a_last   = a_ptr == line_size[rd_slot] - 1'b1;
   assign done     = o_vld && o_last && video_o.tready;
   assign flush_ok = flush_line_i && !empty_o;
   assign free     = done || flush_ok;
   assign rd_next  = free ? inc(rd_slot) : rd_slot;
   // a pop may chain onto the finishing replay, but only if another line remains
   assign pop_ok   = pop_line_i && !flush_line_i && (!rd_busy || done) && (cnt > CNT_WIDTH'(free));

   assign video_o.tvalid = o_vld;
   assign video_o.tlast  = o_last;
   assign video_o.tuser  = o_user;
   assign video_o.tdata  = o_vld ? TDATA_WIDTH'(rdata) : '0;

   // line storage: write port from the input stream, registered read port held while stalled
   always_ff @(posedge clk_i) begin
      if (we) mem[{w_slot, w_ptr}] <= video_i.tdata[PX_WIDTH-1:0];
      if (adv && a_vld) rdata <= mem[{rd_slot, a_ptr}];
   end

   // write pointer, slot commit and overlong-line drop tracking
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_slot   <= '0;
         wr_ptr    <= '0;
         drop_mode <= 1'b0;
      end else begin
         if (commit) begin
            wr_ptr  <= '0;
            wr_slot <= inc(w_slot);
         end else if (we) begin
            wr_ptr  <= w_ptr + 1'b1;
            wr_slot <= w_slot;
         end
         if (wr_acc) drop_mode <= commit ? !video_i.tlast : (drop_mode && !sof_beat && !video_i.tlast);
      end
   end

   // line accounting, slot freeing and the two-stage replay pipeline
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt     <= '0;
         rd_slot <= '0;
         rd_busy <= 1'b0;
         a_vld   <= 1'b0;
         a_ptr   <= '0;
         o_vld   <= 1'b0;
         o_last  <= 1'b0;
         o_user  <= 1'b0;
         sof     <= '0;
         for (int i = 0; i < LINES_CNT; i++) line_size[i] <= '0;
      end else if (sof_beat) begin
         cnt     <= CNT_WIDTH'(commit);
         rd_slot <= '0;
         rd_busy <= 1'b0;
         a_vld   <= 1'b0;
         o_vld   <= 1'b0;
         o_last  <= 1'b0;
         o_user  <= 1'b0;
         sof     <= LINES_CNT'(1);
         if (commit) line_size[0] <= ADDR_WIDTH'(1);
      end else begin
         cnt     <= cnt + CNT_WIDTH'(commit) - CNT_WIDTH'(free);
         rd_slot <= rd_next;
         if (commit) line_size[wr_slot] <= wr_ptr + 1'b1;
         if (free) sof[rd_slot] <= 1'b0;
         if (adv) begin
            o_vld  <= a_vld;
            o_last <= a_vld && a_last;
            o_user <= a_vld && a_ptr == '0 && sof[rd_slot];
            if (a_vld && a_last) a_vld <= 1'b0;
            else a_ptr <= a_ptr + 1'b1;
         end
         if (flush_ok) begin
            rd_busy <= 1'b0;
            a_vld   <= 1'b0;
            o_vld   <= 1'b0;
            o_last  <= 1'b0;
            o_user  <= 1'b0;
         end else if (done) rd_busy <= 1'b0;
         if (pop_ok) begin
            rd_busy <= 1'b1;
            a_vld   <= 1'b1;
            a_ptr   <= '0;
         end
      end
   end
endmodule

// File: tb/tb_multi_line_buf.sv
// tb_multi_line_buf: directed vectors and corner-case sequences for multi_line_buf
module tb_multi_line_buf;
   localparam int MAXL = 8, LINES = 4, TDW = 32, PXW = 8;

   typedef struct {
      bit         pop;
      logic [7:0] base;
      int         len;
      int         olen;
      bit         user;
      bit         rnd;
      logic [2:0] ecnt;
      bit         eempty;
      bit         efull;
   } vec_t;

   logic       clk = 0, rst = 1, pop = 0, flush = 0;
   logic [2:0] cnt;
   logic       empty, full, busy;
   int         checks = 0, errors = 0;
   vec_t       tbl [12];

   axi4_stream_if #(.TDATA_WIDTH(TDW)) vi ();
   axi4_stream_if #(.TDATA_WIDTH(TDW)) vo ();

   multi_line_buf #(.MAX_LINE_SIZE(MAXL), .LINES_CNT(LINES), .TDATA_WIDTH(TDW), .PX_WIDTH(PXW)) dut (
      .clk_i(clk), .rst_i(rst), .pop_line_i(pop), .flush_line_i(flush),
      .video_i(vi), .video_o(vo),
      .lines_cnt_o(cnt), .empty_o(empty), .full_o(full), .rd_busy_o(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_line(input logic [7:0] base, input int n, input bit user);
      for (int i = 0; i < n; i++) begin
         int w;
         w = 0;
         vi.tdata  = 32'(base) + 32'(i);
         vi.tvalid = 1'b1;
         vi.tlast  = (i == n - 1);
         vi.tuser  = user && (i == 0);
         while (!vi.tready && w < 300) begin
            tick();
            w++;
         end
         check($sformatf("send %0h beat %0d ready", base, i), vi.tready, 1);
         if (!vi.tready) break;
         tick();
      end
      vi.tvalid = 1'b0;
      vi.tlast  = 1'b0;
      vi.tuser  = 1'b0;
   endtask

   task automatic pop_check(input string nm, input logic [7:0] base, input int n, input bit user, input bit rnd);
      int got, cyc, first;
      pop = 1'b1;
      tick();
      pop = 1'b0;
      got = 0;
      cyc = 0;
      first = -1;
      while (got < n && cyc < 400) begin
         vo.tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (vo.tvalid && first < 0) first = cyc;
         if (vo.tvalid && vo.tready) begin
            check($sformatf("%s beat %0d", nm, got), {vo.tdata, vo.tlast, vo.tuser},
                  {32'(base) + 32'(got), got == n - 1, user && got == 0});
            got++;
         end
         tick();
         cyc++;
      end
      vo.tready = 1'b1;
      check({nm, " latency"}, first, 1);
      check({nm, " beats"}, got, n);
      check({nm, " idle after"}, {vo.tvalid, busy}, 0);
   endtask

   initial begin
      int got, cyc;
      vi.tdata = '0;
      vi.tvalid = 1'b0;
      vi.tlast = 1'b0;
      vi.tuser = 1'b0;
      vo.tready = 1'b1;
      tbl[0]  = '{0, 8'h10,  5, 5, 1, 0, 3'd1, 0, 0};
      tbl[1]  = '{0, 8'h20,  5, 5, 0, 0, 3'd2, 0, 0};
      tbl[2]  = '{0, 8'h30,  5, 5, 0, 0, 3'd3, 0, 0};
      tbl[3]  = '{1, 8'h10,  5, 5, 1, 0, 3'd2, 0, 0};
      tbl[4]  = '{1, 8'h20,  5, 5, 0, 0, 3'd1, 0, 0};
      tbl[5]  = '{1, 8'h30,  5, 5, 0, 0, 3'd0, 1, 0};
      tbl[6]  = '{0, 8'h40,  6, 6, 0, 0, 3'd1, 0, 0};
      tbl[7]  = '{1, 8'h40,  6, 6, 0, 1, 3'd0, 1, 0};
      tbl[8]  = '{0, 8'h50, 11, 8, 0, 0, 3'd1, 0, 0};
      tbl[9]  = '{0, 8'h60,  3, 3, 0, 0, 3'd2, 0, 0};
      tbl[10] = '{1, 8'h50,  8, 8, 0, 0, 3'd1, 0, 0};
      tbl[11] = '{1, 8'h60,  3, 3, 0, 0, 3'd0, 1, 0};

      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset status", {cnt, empty, full, busy}, {3'd0, 1'b1, 1'b0, 1'b0});
      check("reset streams", {vi.tready, vo.tvalid, vo.tlast, vo.tuser, vo.tdata}, {1'b1, 3'b000, 32'h0});

      pop = 1'b1;
      tick();
      pop = 1'b0;
      repeat (2) tick();
      check("pop when empty", {busy, vo.tvalid, cnt}, 0);

      for (int k = 0; k < 12; k++) begin
         if (tbl[k].pop) pop_check($sformatf("row%0d", k), tbl[k].base, tbl[k].olen, tbl[k].user, tbl[k].rnd);
         else send_line(tbl[k].base, tbl[k].len, tbl[k].user);
         check($sformatf("row%0d status", k), {cnt, empty, full}, {tbl[k].ecnt, tbl[k].eempty, tbl[k].efull});
      end

      send_line(8'h70, 4, 0);
      send_line(8'h80, 4, 0);
      send_line(8'h90, 4, 0);
      send_line(8'hA0, 4, 0);
      check("full", {full, vi.tready, cnt}, {1'b1, 1'b0, 3'd4});
      fork
         send_line(8'hB0, 4, 0);
         begin
            repeat (3) tick();
            check("fifth line stalled", {vi.tvalid, vi.tready}, 2'b10);
            pop_check("pop70", 8'h70, 4, 0, 0);
            check("tready after free", vi.tready, 1);
         end
      join
      check("refilled", {cnt, full}, {3'd4, 1'b1});
      pop_check("pop80", 8'h80, 4, 0, 0);
      pop_check("pop90", 8'h90, 4, 0, 0);
      pop_check("popA0", 8'hA0, 4, 0, 0);
      pop_check("popB0", 8'hB0, 4, 0, 0);
      check("wrap drained", {cnt, empty}, {3'd0, 1'b1});

      send_line(8'hC0, 3, 0);
      send_line(8'hD0, 3, 0);
      check("two stored", cnt, 2);
      vo.tready = 1'b0;
      pop = 1'b1;
      tick();
      pop = 1'b0;
      tick();
      check("stalled output", {vo.tvalid, vo.tdata}, {1'b1, 32'hC0});
      tick();
      check("stalled output held", {vo.tvalid, vo.tdata, vo.tuser}, {1'b1, 32'hC0, 1'b0});
      send_line(8'hE0, 3, 1);
      check("mid-frame sof", {cnt, busy, vo.tvalid}, {3'd1, 1'b0, 1'b0});
      vo.tready = 1'b1;
      pop_check("sof pop", 8'hE0, 3, 1, 0);
      check("sof drained", empty, 1);

      send_line(8'h01, 5, 0);
      send_line(8'h21, 4, 0);
      pop = 1'b1;
      tick();
      pop = 1'b0;
      got = 0;
      cyc = 0;
      while (got < 2 && cyc < 20) begin
         if (vo.tvalid && vo.tready) begin
            check($sformatf("pre-flush beat %0d", got), vo.tdata, 32'h01 + 32'(got));
            got++;
         end
         tick();
         cyc++;
      end
      check("pre-flush beats", got, 2);
      flush = 1'b1;
      vo.tready = 1'b0;
      tick();
      flush = 1'b0;
      vo.tready = 1'b1;
      check("after flush", {vo.tvalid, busy, cnt}, {1'b0, 1'b0, 3'd1});
      pop_check("post-flush pop", 8'h21, 4, 0, 0);
      check("final empty", {cnt, empty, full}, {3'd0, 1'b1, 1'b0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
